core_obi_arbiter: RTL
=====================

Name: core_obi_arbiter

Overview:
- Shares one memory manager port between the core's instruction-fetch and data-access interfaces.
- Arbitrates requests round-robin and keeps the request stable while it waits for a grant.
- Records the owner of each outstanding transaction in order, then routes each response back to that owner.
- Sits between the core wrapper and a single-ported SRAM/interconnect port in the SoC.

Parameters:
- MaxTrans, 2, maximum outstanding granted-but-unanswered transactions (1..4).
- AddrWidth, 32, address width.
- DataWidth, 32, data width; byte-enable width is DataWidth/8.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  AddrWidth  fetch address
- instr_gnt_o  out  1  fetch grant
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  DataWidth  fetch read data
- instr_err_o  out  1  fetch response error
- data_req_i  in  1  data request
- data_we_i  in  1  data write enable
- data_be_i  in  DataWidth/8  data byte enables
- data_addr_i  in  AddrWidth  data address
- data_wdata_i  in  DataWidth  data write data
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  DataWidth  data read data
- data_err_o  out  1  data response error
- mgr_req_o  out  1  manager request
- mgr_we_o  out  1  manager write enable
- mgr_be_o  out  DataWidth/8  manager byte enables
- mgr_addr_o  out  AddrWidth  manager address
- mgr_wdata_o  out  DataWidth  manager write data
- mgr_gnt_i  in  1  manager grant
- mgr_rvalid_i  in  1  manager response valid
- mgr_rdata_i  in  DataWidth  manager read data
- mgr_err_i  in  1  manager response error
- busy_o  out  1  outstanding count nonzero
- rsp_err_o  out  1  sticky flag: response received with no transaction outstanding

Behaviour:
- Reset values: all outputs 0; outstanding count 0; owner FIFO empty; round-robin pointer = INSTR; lock cleared; rsp_err_o 0.
- Full condition: full = (count == MaxTrans).
- Request gating:
  - While full, mgr_req_o = 0 and no grant is given.
  - There is no same-cycle pass-through on a pop when full; grants resume the cycle after count drops.
- Selection when not full:
  - If locked, select the locked owner.
  - Otherwise, with a single requester, select it.
  - With both requesting, select the owner that is not the pointer's last grant.
- Manager request mux: mgr_req_o = selected req. Address, we, be and wdata come from the selected port.
- Instruction-port driving: when the instruction port is selected, mgr_we_o = 0, mgr_be_o = all ones, mgr_wdata_o = 0.
- Lock: if mgr_req_o && !mgr_gnt_i, lock the current owner for the next cycle. Selection and address then stay stable until the grant (OBI stability). The lock clears on grant.
- Grant: selected_gnt_o = mgr_gnt_i && mgr_req_o; the other port's gnt = 0. The grant is combinational, zero cycles.
- On grant:
  - Push the owner into the FIFO and set the pointer to that owner.
  - count += 1, unless a pop occurs in the same cycle, in which case count is unchanged.
- On mgr_rvalid_i:
  - Pop the FIFO head.
  - Drive the owner's rvalid, rdata and err in the same cycle (combinational, zero latency).
  - The other port's rvalid = 0 and its rdata = 0.
- Response timing: responses are strictly in order. mgr_rvalid_i may arrive the cycle after its grant at the earliest.
- Stray response: mgr_rvalid_i with count 0 is dropped (no port rvalid) and sets rsp_err_o. rsp_err_o clears only on reset.
- FIFO pointers: wrap modulo MaxTrans.
- Busy: busy_o = (count != 0), registered view of count.
- Reset mid-operation: all state is cleared asynchronously. Responses still in flight afterwards are treated as stray.

Decomposition:
- croc_pkg additions: typedef enum logic {OWNER_INSTR, OWNER_DATA} obi_owner_e; localparam MaxCoreTrans = 2.
- Sub-module core_obi_id_fifo: MaxTrans-deep FIFO of obi_owner_e with push, pop, full, empty and count outputs.
- Top level holds the arbitration, lock and mux logic.

Test Plan:
- Fetch alone: instr_req_i=1, addr 0x1000_0080, gnt immediate, rvalid next cycle with rdata 0xDEADBEEF -> instr_gnt_o same cycle, instr_rdata_o=0xDEADBEEF, data ports idle, busy_o high for 1 cycle.
- Contention: both requesting every cycle with gnt=1 -> grants alternate INSTR, DATA, INSTR, DATA; the first grant goes to DATA because the pointer resets to INSTR.
- Stall: mgr_gnt_i=0 for 3 cycles while both request, with data selected first -> mgr_addr_o holds the data address for all 3 cycles; instr never granted until data is granted.
- Full: MaxTrans=2, two grants with no rvalid -> mgr_req_o=0 in cycle 3; after one rvalid, mgr_req_o returns the next cycle.
- Routing and errors: grant instr then data; rvalid with err=0 then rvalid with err=1 -> instr_rvalid_o and then data_rvalid_o with data_err_o=1.
- Stray response: mgr_rvalid_i pulse with count 0 -> no port rvalid, rsp_err_o=1 and sticky until rst_ni low.

Source files
------------

// File: rtl/core_obi_arbiter_pkg.sv
// Shared types and constants for the core OBI arbiter.
//   obi_owner_e   : which core interface owns a manager-port transaction
//   MaxCoreTrans  : default outstanding-transaction depth
//   MaxTransLimit : largest supported depth (storage is sized for this)
//   CntWidth      : width of outstanding counters (holds 0..MaxTransLimit)
//   PtrWidth      : width of FIFO read/write pointers
package core_obi_arbiter_pkg;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } obi_owner_e;

  localparam int unsigned MaxCoreTrans  = 2;
  localparam int unsigned MaxTransLimit = 4;
  localparam int unsigned CntWidth      = 3;
  localparam int unsigned PtrWidth      = 2;

  // The port that did not win the previous round-robin decision.
  function automatic obi_owner_e other_owner(input obi_owner_e owner);
    return (owner == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
  endfunction

endpackage

// File: rtl/core_obi_id_fifo.sv
// In-order record of which core port owns each outstanding transaction.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push_i          : append push_owner_i (ignored while full)
//   push_owner_i    : owner of the transaction just granted
//   pop_i           : drop the head entry (ignored while empty)
//   head_o          : owner of the oldest outstanding transaction
//   full_o, empty_o : occupancy flags
//   count_o         : number of outstanding entries
module core_obi_id_fifo
  import core_obi_arbiter_pkg::*;
#(
  parameter int unsigned MaxTrans = MaxCoreTrans
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  obi_owner_e          push_owner_i,
  input  logic                pop_i,
  output obi_owner_e          head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] count_o
);

  obi_owner_e          mem_reg [MaxTransLimit];
  logic [PtrWidth-1:0] wr_ptr_reg;
  logic [PtrWidth-1:0] rd_ptr_reg;
  logic [CntWidth-1:0] count_reg;
  logic                do_push;
  logic                do_pop;

  // Pointers wrap at MaxTrans, not at the storage size, so any depth 1..4 works.
  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(MaxTrans - 1)) ? '0 : ptr + PtrWidth'(1);
  endfunction

  assign full_o  = (count_reg == CntWidth'(MaxTrans));
  assign empty_o = (count_reg == '0);
  assign count_o = count_reg;
  assign head_o  = mem_reg[rd_ptr_reg];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < MaxTransLimit; i++) begin
        mem_reg[i] <= OWNER_INSTR;
      end
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_owner_i;
        wr_ptr_reg          <= next_ptr(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= next_ptr(rd_ptr_reg);
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + CntWidth'(1);
      end else if (do_pop && !do_push) begin
        count_reg <= count_reg - CntWidth'(1);
      end
    end
  end

endmodule

// File: rtl/core_obi_arbiter.sv
// Shares one OBI manager port between the core's fetch and data interfaces.
// Round-robin arbitration, request held stable until granted, responses
// routed back in order to the port that issued the transaction.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   instr_*              : fetch interface (read-only)
//   data_*               : data interface (read/write)
//   mgr_*                : shared manager port towards memory/interconnect
//   busy_o               : at least one transaction outstanding
//   rsp_err_o            : sticky, a response arrived with nothing outstanding
module core_obi_arbiter
  import core_obi_arbiter_pkg::*;
#(
  parameter int unsigned MaxTrans  = MaxCoreTrans,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   instr_req_i,
  input  logic [AddrWidth-1:0]   instr_addr_i,
  output logic                   instr_gnt_o,
  output logic                   instr_rvalid_o,
  output logic [DataWidth-1:0]   instr_rdata_o,
  output logic                   instr_err_o,
  input  logic                   data_req_i,
  input  logic                   data_we_i,
  input  logic [DataWidth/8-1:0] data_be_i,
  input  logic [AddrWidth-1:0]   data_addr_i,
  input  logic [DataWidth-1:0]   data_wdata_i,
  output logic                   data_gnt_o,
  output logic                   data_rvalid_o,
  output logic [DataWidth-1:0]   data_rdata_o,
  output logic                   data_err_o,
  output logic                   mgr_req_o,
  output logic                   mgr_we_o,
  output logic [DataWidth/8-1:0] mgr_be_o,
  output logic [AddrWidth-1:0]   mgr_addr_o,
  output logic [DataWidth-1:0]   mgr_wdata_o,
  input  logic                   mgr_gnt_i,
  input  logic                   mgr_rvalid_i,
  input  logic [DataWidth-1:0]   mgr_rdata_i,
  input  logic                   mgr_err_i,
  output logic                   busy_o,
  output logic                   rsp_err_o
);

  obi_owner_e          last_grant_reg;
  obi_owner_e          lock_owner_reg;
  logic                lock_reg;
  logic                rsp_err_reg;
  obi_owner_e          sel;
  logic                sel_req;
  logic                grant;
  logic                fifo_full;
  logic                fifo_empty;
  obi_owner_e          fifo_head;
  logic [CntWidth-1:0] fifo_count;
  logic                rsp_valid;
  logic                stray_rsp;

  // Owner selection: a stalled request keeps its slot; otherwise the port
  // that lost the previous contended round wins.
  always_comb begin
    sel = OWNER_INSTR;
    if (lock_reg) begin
      sel = lock_owner_reg;
    end else if (instr_req_i && data_req_i) begin
      sel = other_owner(last_grant_reg);
    end else if (data_req_i) begin
      sel = OWNER_DATA;
    end
  end

  assign sel_req   = (sel == OWNER_DATA) ? data_req_i : instr_req_i;
  // No issue while full; a pop this cycle only frees a slot for next cycle.
  assign mgr_req_o = sel_req && !fifo_full;
  assign grant     = mgr_req_o && mgr_gnt_i;

  assign instr_gnt_o = grant && (sel == OWNER_INSTR);
  assign data_gnt_o  = grant && (sel == OWNER_DATA);

  // Request payload; fetches are full-word reads.
  always_comb begin
    mgr_we_o    = 1'b0;
    mgr_be_o    = '0;
    mgr_addr_o  = '0;
    mgr_wdata_o = '0;
    if (mgr_req_o) begin
      if (sel == OWNER_DATA) begin
        mgr_we_o    = data_we_i;
        mgr_be_o    = data_be_i;
        mgr_addr_o  = data_addr_i;
        mgr_wdata_o = data_wdata_i;
      end else begin
        mgr_be_o   = '1;
        mgr_addr_o = instr_addr_i;
      end
    end
  end

  // Responses with nothing outstanding are dropped and flagged.
  assign rsp_valid = mgr_rvalid_i && !fifo_empty;
  assign stray_rsp = mgr_rvalid_i && fifo_empty;

  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    instr_err_o    = 1'b0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = '0;
    data_err_o     = 1'b0;
    if (rsp_valid) begin
      if (fifo_head == OWNER_DATA) begin
        data_rvalid_o = 1'b1;
        data_rdata_o  = mgr_rdata_i;
        data_err_o    = mgr_err_i;
      end else begin
        instr_rvalid_o = 1'b1;
        instr_rdata_o  = mgr_rdata_i;
        instr_err_o    = mgr_err_i;
      end
    end
  end

  core_obi_id_fifo #(
    .MaxTrans (MaxTrans)
  ) u_id_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (grant),
    .push_owner_i (sel),
    .pop_i        (rsp_valid),
    .head_o       (fifo_head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count)
  );

  assign busy_o    = (fifo_count != '0);
  assign rsp_err_o = rsp_err_reg;

  // The lock is re-evaluated every cycle: it holds exactly while a request
  // is pending without grant, which also drops it if the owner withdraws.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_reg <= OWNER_INSTR;
      lock_owner_reg <= OWNER_INSTR;
      lock_reg       <= 1'b0;
      rsp_err_reg    <= 1'b0;
    end else begin
      lock_reg       <= mgr_req_o && !mgr_gnt_i;
      lock_owner_reg <= sel;
      if (grant) begin
        last_grant_reg <= sel;
      end
      if (stray_rsp) begin
        rsp_err_reg <= 1'b1;
      end
    end
  end

endmodule
